// File: rtl/time_counter_checker_if.sv
// Observation bundle between a time counter and its checker: sampled counter
// signals in, prediction, status and statistics out.
interface time_counter_checker_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) ();
    logic              clear;
    logic              enable;
    logic [WIDTH-1:0]  count;
    logic [WIDTH-1:0]  expected;
    logic              locked;
    logic              mismatch;
    logic              fault;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output clear, enable, count,
        input  expected, locked, mismatch, fault, wrap, wrap_cnt, err_cnt
    );

    modport slave (
        input  clear, enable, count,
        output expected, locked, mismatch, fault, wrap, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/time_counter_checker.sv
// Monitors an enable-gated wrapping counter, predicting each sample from the
// previous one and keeping saturating counts of correct wraps and mismatches.
module time_counter_checker #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8,
    parameter int STICKY = 1
) (
    input  logic                  clk,
    input  logic                  clrn,
    time_counter_checker_if.slave mon
);
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_count_q, prev_count_d;
    logic              prev_en_q;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  expected_c;

    // The observed counter reacts to the enable it saw on the previous edge.
    assign expected_c = prev_en_q ? prev_count_q + WIDTH'(1) : prev_count_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            prev_count_q <= '0;
            prev_en_q    <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
            mismatch_q   <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_en_q    <= mon.enable;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            mismatch_q   <= mismatch_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_count_d = prev_count_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;
        mismatch_d   = 1'b0;
        wrap_d       = 1'b0;
        if (mon.clear) begin
            state_d      = IDLE;
            prev_count_d = '0;
            wrap_cnt_d   = '0;
            err_cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    prev_count_d = mon.count;
                    state_d      = TRACK;
                end
                TRACK: begin
                    if (mon.count == expected_c) begin
                        prev_count_d = mon.count;
                        if (prev_en_q && (prev_count_q == '1) && (mon.count == '0)) begin
                            wrap_d = 1'b1;
                            if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                        if (STICKY != 0) state_d = FAULT;
                        else             prev_count_d = mon.count;
                    end
                end
                FAULT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mon.expected = expected_c;
    assign mon.locked   = (state_q == TRACK);
    assign mon.fault    = (state_q == FAULT);
    assign mon.mismatch = mismatch_q;
    assign mon.wrap     = wrap_q;
    assign mon.wrap_cnt = wrap_cnt_q;
    assign mon.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_time_counter_checker.sv
// Three checker configurations observe one shared, occasionally corrupted
// counter stream; a per-cycle scoreboard compares them with abstract models.
module tb_time_counter_checker;
    localparam int M = 16;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    time_counter_checker_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) b0 ();
    time_counter_checker_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) b1 ();
    time_counter_checker_if #(.WIDTH(4), .WRAP_W(2), .ERR_W(2)) b2 ();

    time_counter_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(8), .STICKY(1))
        u0 (.clk(clk), .clrn(clrn), .mon(b0));
    time_counter_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(8), .STICKY(0))
        u1 (.clk(clk), .clrn(clrn), .mon(b1));
    time_counter_checker #(.WIDTH(4), .WRAP_W(2), .ERR_W(2), .STICKY(0))
        u2 (.clk(clk), .clrn(clrn), .mon(b2));

    // Model state: phase 0 = waiting to capture, 1 = following, 2 = halted.
    typedef struct {
        int phase, last, last_en, wraps, errs, bad_pulse, wrap_pulse;
    } mdl_t;
    typedef struct {
        logic [31:0] ex, lk, mm, ft, wr, wc, ec;
    } obs_t;

    int   STK [3] = '{1, 0, 0};
    int   WMX [3] = '{255, 255, 3};
    int   EMX [3] = '{255, 255, 3};
    mdl_t m [3];
    obs_t q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ctr   = 0;

    function automatic mdl_t mreset();
        mdl_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic int predict(mdl_t s);
        return s.last_en != 0 ? (s.last + 1) % M : s.last;
    endfunction

    function automatic mdl_t step(mdl_t s, bit clr, bit en, int cnt, int k);
        mdl_t n;
        n = s;
        n.bad_pulse  = 0;
        n.wrap_pulse = 0;
        if (clr) begin
            n.phase = 0; n.last = 0; n.wraps = 0; n.errs = 0;
        end else if (s.phase == 0) begin
            n.last  = cnt;
            n.phase = 1;
        end else if (s.phase == 1) begin
            if (cnt == predict(s)) begin
                n.last = cnt;
                if (s.last_en != 0 && s.last == M - 1 && cnt == 0) begin
                    n.wrap_pulse = 1;
                    n.wraps = (s.wraps < WMX[k]) ? s.wraps + 1 : s.wraps;
                end
            end else begin
                n.bad_pulse = 1;
                n.errs = (s.errs < EMX[k]) ? s.errs + 1 : s.errs;
                if (STK[k] != 0) n.phase = 2;
                else             n.last  = cnt;
            end
        end
        n.last_en = en ? 1 : 0;
        return n;
    endfunction

    function automatic obs_t view(mdl_t s);
        obs_t o;
        o.ex = predict(s);
        o.lk = 32'(s.phase == 1);
        o.ft = 32'(s.phase == 2);
        o.mm = s.bad_pulse;
        o.wr = s.wrap_pulse;
        o.wc = s.wraps;
        o.ec = s.errs;
        return o;
    endfunction

    function automatic obs_t act(int k);
        obs_t o;
        case (k)
            0: begin
                o.ex = 32'(b0.expected); o.lk = 32'(b0.locked); o.mm = 32'(b0.mismatch);
                o.ft = 32'(b0.fault); o.wr = 32'(b0.wrap); o.wc = 32'(b0.wrap_cnt); o.ec = 32'(b0.err_cnt);
            end
            1: begin
                o.ex = 32'(b1.expected); o.lk = 32'(b1.locked); o.mm = 32'(b1.mismatch);
                o.ft = 32'(b1.fault); o.wr = 32'(b1.wrap); o.wc = 32'(b1.wrap_cnt); o.ec = 32'(b1.err_cnt);
            end
            default: begin
                o.ex = 32'(b2.expected); o.lk = 32'(b2.locked); o.mm = 32'(b2.mismatch);
                o.ft = 32'(b2.fault); o.wr = 32'(b2.wrap); o.wc = 32'(b2.wrap_cnt); o.ec = 32'(b2.err_cnt);
            end
        endcase
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, a, e);
        end
    endtask

    task automatic cmp_all(int k, obs_t a, obs_t e);
        chk($sformatf("u%0d.expected", k), a.ex, e.ex);
        chk($sformatf("u%0d.locked",   k), a.lk, e.lk);
        chk($sformatf("u%0d.mismatch", k), a.mm, e.mm);
        chk($sformatf("u%0d.fault",    k), a.ft, e.ft);
        chk($sformatf("u%0d.wrap",     k), a.wr, e.wr);
        chk($sformatf("u%0d.wrap_cnt", k), a.wc, e.wc);
        chk($sformatf("u%0d.err_cnt",  k), a.ec, e.ec);
    endtask

    // One clock of stimulus: inputs for the coming edge plus expected results.
    task automatic cycle(bit clr, bit en, bit bad, bit rst = 1'b0);
        int cv;
        @(negedge clk);
        clrn = !rst;
        cv = ctr;
        if (bad) cv = ctr ^ int'($urandom_range(1, M - 1));
        b0.clear = clr; b0.enable = en; b0.count = 4'(cv);
        b1.clear = clr; b1.enable = en; b1.count = 4'(cv);
        b2.clear = clr; b2.enable = en; b2.count = 4'(cv);
        for (int k = 0; k < 3; k++) begin
            if (rst) m[k] = mreset();
            else     m[k] = step(m[k], clr, en, cv, k);
            q.push_back(view(m[k]));
        end
        ctr = en ? (cv + 1) % M : cv;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() >= 3) begin
                for (int k = 0; k < 3; k++) begin
                    e = q.pop_front();
                    cmp_all(k, act(k), e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "time limit");
    end

    initial begin : stim
        obs_t z;
        z = '{default: '0};
        for (int k = 0; k < 3; k++) m[k] = mreset();
        b0.clear = 1'b0; b0.enable = 1'b0; b0.count = '0;
        b1.clear = 1'b0; b1.enable = 1'b0; b1.count = '0;
        b2.clear = 1'b0; b2.enable = 1'b0; b2.count = '0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        repeat (20) cycle(1'b0, 1'b1, 1'b0);

        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0);

        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, bit'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);

        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (6) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b0);
        end

        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);

        repeat (400)
            cycle($urandom_range(0, 99) == 0, bit'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15) == 0);

        // Reset dropped between edges must take effect without a clock.
        @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            m[k] = mreset();
            cmp_all(k, act(k), z);
        end
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (12) cycle(1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
